// File: rtl/ritmo_pkg.sv
// Shared definitions for the rhythm-game sequencing blocks.
package ritmo_pkg;

    localparam int CMD_W  = 4;
    localparam int ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GAP,
        ST_SPAWN,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/slot_rr_picker.sv
// Round-robin free-slot picker: first free slot at or after rr_ptr, with wrap.
module slot_rr_picker #(
    parameter int N_SLOTS = 3
) (
    input  logic [N_SLOTS-1:0] free,
    input  logic [2:0]         rr_ptr,
    output logic [2:0]         pick,
    output logic               any_free
);

    logic [7:0] free_ext;
    logic [2:0] idx;

    always_comb begin
        free_ext = 8'(free);
        pick     = '0;
        any_free = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < N_SLOTS; k++) begin
            idx = 3'((32'(rr_ptr) + k) % N_SLOTS);
            if (!any_free && free_ext[idx]) begin
                any_free = 1'b1;
                pick     = idx;
            end
        end
    end

endmodule

// File: rtl/pattern_scheduler.sv
// Spawns list-ROM commands into free pattern slots at a frame-based interval
// and accumulates saturating hit/miss counts until the list drains.
module pattern_scheduler
    import ritmo_pkg::*;
#(
    parameter int N_SLOTS    = 3,
    parameter int LIST_LEN   = 10,
    parameter int GAP_FRAMES = 16,
    parameter int SCORE_W    = 8
) (
    input  logic               CLOCK_25,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               enable,
    output logic [3:0]         cmd_addr,
    input  logic [3:0]         cmd_data,
    input  logic [N_SLOTS-1:0] slot_busy,
    input  logic [N_SLOTS-1:0] slot_hit,
    input  logic [N_SLOTS-1:0] slot_miss,
    output logic [N_SLOTS-1:0] spawn,
    output logic [3:0]         spawn_cmd,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         miss_count,
    output logic               game_over
);

    localparam int GAP_W = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;
    localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(GAP_FRAMES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(LIST_LEN - 1);
    localparam logic [2:0]        LAST_SLOT  = 3'(N_SLOTS - 1);
    localparam logic [31:0]       SCORE_MAX  = 32'((1 << SCORE_W) - 1);
    localparam logic [31:0]       MISS_MAX   = 32'd255;

    function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                            input logic [7:0]  mask,
                                            input logic [31:0] max_val);
        logic [31:0] sum;
        sum = acc;
        for (int unsigned i = 0; i < 8; i++) begin
            sum = sum + 32'(mask[i]);
        end
        return (sum > max_val) ? max_val : sum;
    endfunction

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    cmd_addr_q, cmd_addr_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [2:0]           rr_q, rr_d;
    logic [2:0]           pick_q, pick_d;
    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic [N_SLOTS-1:0]   pending_q, pending_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [7:0]           miss_q, miss_d;

    logic [N_SLOTS-1:0]   free;
    logic [2:0]           pick;
    logic                 any_free;

    assign free = ~slot_busy & ~pending_q;

    slot_rr_picker #(.N_SLOTS(N_SLOTS)) u_picker (
        .free     (free),
        .rr_ptr   (rr_q),
        .pick     (pick),
        .any_free (any_free)
    );

    // Spawn is decoded from the registered state so it is a clean 1-cycle pulse.
    assign spawn      = (state_q == ST_SPAWN) ? (N_SLOTS'(1) << pick_q) : '0;
    assign spawn_cmd  = (state_q == ST_SPAWN) ? cmd_q : '0;
    assign cmd_addr   = cmd_addr_q;
    assign score      = score_q;
    assign miss_count = miss_q;
    assign game_over  = (state_q == ST_DONE);

    always_comb begin
        state_d    = state_q;
        cmd_addr_d = cmd_addr_q;
        gap_d      = gap_q;
        rr_d       = rr_q;
        pick_d     = pick_q;
        cmd_d      = cmd_q;
        score_d    = score_q;
        miss_d     = miss_q;
        pending_d  = (pending_q & ~slot_busy) | spawn;

        if (state_q == ST_WAIT_GAP || state_q == ST_SPAWN || state_q == ST_DRAIN) begin
            score_d = SCORE_W'(sat_add(32'(score_q), 8'(slot_hit), SCORE_MAX));
            miss_d  = 8'(sat_add(32'(miss_q), 8'(slot_miss), MISS_MAX));
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT_GAP;
                    gap_d   = '0;
                end
            end
            ST_WAIT_GAP: begin
                if (enable) begin
                    if (gap_q != '0) begin
                        if (frame_tick) gap_d = gap_q - 1'b1;
                    end else if (any_free) begin
                        state_d = ST_SPAWN;
                        pick_d  = pick;
                        cmd_d   = cmd_data;
                    end
                end
            end
            ST_SPAWN: begin
                cmd_addr_d = cmd_addr_q + 1'b1;
                gap_d      = GAP_RELOAD;
                rr_d       = (pick_q == LAST_SLOT) ? 3'd0 : pick_q + 3'd1;
                state_d    = (cmd_addr_q == LAST_ADDR) ? ST_DRAIN : ST_WAIT_GAP;
            end
            ST_DRAIN: begin
                if (slot_busy == '0 && pending_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cmd_addr_q <= '0;
            gap_q      <= '0;
            rr_q       <= '0;
            pick_q     <= '0;
            cmd_q      <= '0;
            pending_q  <= '0;
            score_q    <= '0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            cmd_addr_q <= cmd_addr_d;
            gap_q      <= gap_d;
            rr_q       <= rr_d;
            pick_q     <= pick_d;
            cmd_q      <= cmd_d;
            pending_q  <= pending_d;
            score_q    <= score_d;
            miss_q     <= miss_d;
        end
    end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Randomized scoreboard bench for pattern_scheduler against a cycle-level behavioural model.
module tb_pattern_scheduler;

    localparam int N    = 3;
    localparam int LEN  = 6;
    localparam int GAP  = 4;
    localparam int SW   = 8;
    localparam int NCYC = 15000;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_tick;
    logic          enable;
    logic [3:0]    cmd_addr;
    logic [3:0]    cmd_data;
    logic [N-1:0]  slot_busy;
    logic [N-1:0]  slot_hit;
    logic [N-1:0]  slot_miss;
    logic [N-1:0]  spawn;
    logic [3:0]    spawn_cmd;
    logic [SW-1:0] score;
    logic [7:0]    miss_count;
    logic          game_over;

    always #5 clk = ~clk;

    logic [3:0] rom [16];
    assign cmd_data = rom[cmd_addr];

    pattern_scheduler #(
        .N_SLOTS    (N),
        .LIST_LEN   (LEN),
        .GAP_FRAMES (GAP),
        .SCORE_W    (SW)
    ) dut (
        .CLOCK_25   (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .enable     (enable),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .slot_busy  (slot_busy),
        .slot_hit   (slot_hit),
        .slot_miss  (slot_miss),
        .spawn      (spawn),
        .spawn_cmd  (spawn_cmd),
        .score      (score),
        .miss_count (miss_count),
        .game_over  (game_over)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit run_mon = 1'b0;

    typedef struct {
        int slot;
        int cmd;
        int due;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_tests++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: game progress tracked as plain counters and flags.
    bit m_started, m_in_spawn, m_drain, m_done;
    int m_gap, m_rr, m_pick, m_cmd, m_next, m_score, m_miss;
    bit m_pend [N];

    task automatic model_reset();
        m_started = 0; m_in_spawn = 0; m_drain = 0; m_done = 0;
        m_gap = 0; m_rr = 0; m_pick = 0; m_cmd = 0; m_next = 0;
        m_score = 0; m_miss = 0;
        for (int i = 0; i < N; i++) m_pend[i] = 0;
    endtask

    task automatic model_step(input bit rst, input bit en, input bit ft,
                              input logic [N-1:0] busy, input logic [N-1:0] hit,
                              input logic [N-1:0] miss);
        bit newp [N];
        bit idle_all;
        bit found;
        int idx;
        exp_t e;
        if (rst) begin
            model_reset();
            return;
        end
        idle_all = 1;
        for (int i = 0; i < N; i++) begin
            newp[i] = (m_pend[i] && !busy[i]) || (m_in_spawn && m_pick == i);
            if (busy[i] || m_pend[i]) idle_all = 0;
        end
        if (m_started && !m_done) begin
            m_score = m_score + $countones(hit);
            if (m_score > (1 << SW) - 1) m_score = (1 << SW) - 1;
            m_miss = m_miss + $countones(miss);
            if (m_miss > 255) m_miss = 255;
        end
        if (!m_started) begin
            if (en) begin
                m_started = 1;
                m_gap = 0;
            end
        end else if (m_in_spawn) begin
            m_in_spawn = 0;
            m_next++;
            m_gap = GAP - 1;
            m_rr = (m_pick + 1) % N;
            if (m_next == LEN) m_drain = 1;
        end else if (m_drain) begin
            if (idle_all) begin
                m_drain = 0;
                m_done = 1;
            end
        end else if (!m_done && en) begin
            if (m_gap != 0) begin
                if (ft) m_gap--;
            end else begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (!found && !busy[idx] && !m_pend[idx]) begin
                        found = 1;
                        m_pick = idx;
                    end
                end
                if (found) begin
                    m_in_spawn = 1;
                    m_cmd = int'(rom[m_next]);
                    e.slot = m_pick;
                    e.cmd = m_cmd;
                    e.due = cyc + 1;
                    sb.push_back(e);
                end
            end
        end
        for (int i = 0; i < N; i++) m_pend[i] = newp[i];
    endtask

    // Monitor: every spawn pulse is matched against the oldest expected spawn.
    always @(negedge clk) begin
        exp_t e;
        if (run_mon) begin
            if (spawn != '0) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spawn_unexpected: got spawn=%b, expected none (cycle %0d)", spawn, cyc);
                end else begin
                    e = sb.pop_front();
                    check("spawn_slot", 32'(spawn), 1 << e.slot);
                    check("spawn_cmd", 32'(spawn_cmd), e.cmd);
                    check("spawn_cycle", 32'(cyc), e.due);
                end
            end else begin
                check("spawn_cmd_idle", 32'(spawn_cmd), 0);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spawn_missing: got spawn=0, expected slot %0d (cycle %0d)", sb[0].slot, cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int  life [N];
        bit  arm [N];
        bit  paused, long_mode, hit_burst, miss_burst, rst;
        int  done_cnt, r;
        logic [N-1:0] busy_v, hit_v, miss_v;

        for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
        for (int i = 0; i < N; i++) begin
            life[i] = 0;
            arm[i] = 0;
        end
        paused = 0; long_mode = 0; hit_burst = 0; miss_burst = 0; done_cnt = 0;
        reset = 1'b1; enable = 1'b0; frame_tick = 1'b0;
        slot_busy = '0; slot_hit = '0; slot_miss = '0;
        model_reset();
        @(posedge clk);
        #1;
        run_mon = 1'b1;

        for (int it = 0; it < NCYC; it++) begin
            if (it != 0) begin
                @(posedge clk);
                #1;
            end
            check("cmd_addr", 32'(cmd_addr), m_next);
            check("game_over", 32'(game_over), int'(m_done));
            check("score", 32'(score), m_score);
            check("miss_count", 32'(miss_count), m_miss);

            done_cnt = m_done ? done_cnt + 1 : 0;
            rst = (done_cnt > 8) || ($urandom_range(0, 1499) == 0) ||
                  (m_drain && $urandom_range(0, 59) == 0);
            if (rst) begin
                long_mode  = ($urandom_range(0, 2) == 0);
                hit_burst  = ($urandom_range(0, 1) == 0);
                miss_burst = ($urandom_range(0, 1) == 0);
            end
            if ($urandom_range(0, 39) == 0) paused = ~paused;

            hit_v = '0;
            miss_v = '0;
            for (int i = 0; i < N; i++) begin
                if (arm[i]) begin
                    life[i] = long_mode ? $urandom_range(20, 150) : $urandom_range(2, 10);
                    arm[i] = 0;
                end else if (life[i] > 0) begin
                    life[i]--;
                    if (life[i] == 0) begin
                        r = $urandom_range(0, 3);
                        hit_v[i]  = (r != 1);
                        miss_v[i] = (r == 1 || r == 3);
                    end
                end
                busy_v[i] = (life[i] > 0);
                if (spawn[i]) arm[i] = 1;
            end
            if (hit_burst && $urandom_range(0, 1) == 0) hit_v = hit_v | N'($urandom);
            if (miss_burst && $urandom_range(0, 2) == 0) miss_v = miss_v | N'($urandom);
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    life[i] = 0;
                    arm[i] = 0;
                end
            end

            reset      = rst;
            enable     = !paused;
            frame_tick = ($urandom_range(0, 2) == 0);
            slot_busy  = busy_v;
            slot_hit   = hit_v;
            slot_miss  = miss_v;
            model_step(rst, !paused, frame_tick, busy_v, hit_v, miss_v);
        end

        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
